// File: rtl/countdown_timer.sv
// Minute:second countdown with one-second prescaler, start-edge detect and BCD digit outputs.
// Feeds the seven-segment driver and signals completion to the fan control logic.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] min_in,
    input  logic [7:0] sec_in,
    input  logic       count_begin,
    input  logic       abort,
    output logic [7:0] min_left,
    output logic [7:0] sec_left,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expired
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);

    state_t      state;
    logic [25:0] presc;
    logic        begin_q;
    logic        start;
    logic        drop;
    logic        tick;
    logic        preset_zero;
    logic [7:0]  min_c;
    logic [7:0]  sec_c;

    assign start       = count_begin & ~begin_q;
    assign drop        = begin_q & ~count_begin;
    assign tick        = (presc == TICK_LAST);
    assign min_c       = (min_in > 8'd59) ? 8'd59 : min_in;
    assign sec_c       = (sec_in > 8'd59) ? 8'd59 : sec_in;
    assign preset_zero = (min_c == 8'd0) && (sec_c == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            begin_q  <= 1'b0;
            min_left <= '0;
            sec_left <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            begin_q <= count_begin;
            done    <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                presc    <= '0;
                running  <= 1'b0;
                expired  <= 1'b0;
                min_left <= min_c;
                sec_left <= sec_c;
            end else begin
                case (state)
                    // IDLE and DONE share the start rules; DONE only falls back on a count_begin drop
                    IDLE, DONE: begin
                        if (start) begin
                            presc <= '0;
                            if (preset_zero) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                expired  <= 1'b1;
                                running  <= 1'b0;
                                min_left <= '0;
                                sec_left <= '0;
                            end else begin
                                state    <= RUN;
                                running  <= 1'b1;
                                expired  <= 1'b0;
                                min_left <= min_c;
                                sec_left <= sec_c;
                            end
                        end else if ((state == IDLE) || drop) begin
                            state    <= IDLE;
                            expired  <= 1'b0;
                            min_left <= min_c;
                            sec_left <= sec_c;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            presc <= '0;
                            if (sec_left != 8'd0) begin
                                sec_left <= sec_left - 8'd1;
                                if ((sec_left == 8'd1) && (min_left == 8'd0)) begin
                                    state   <= DONE;
                                    done    <= 1'b1;
                                    expired <= 1'b1;
                                    running <= 1'b0;
                                end
                            end else if (min_left != 8'd0) begin
                                min_left <= min_left - 8'd1;
                                sec_left <= 8'd59;
                            end
                        end else begin
                            presc <= presc + 26'd1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        expired <= 1'b0;
                    end
                endcase
            end
        end
    end

    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [3:0] t;
        if (v >= 8'd50)      t = 4'd5;
        else if (v >= 8'd40) t = 4'd4;
        else if (v >= 8'd30) t = 4'd3;
        else if (v >= 8'd20) t = 4'd2;
        else if (v >= 8'd10) t = 4'd1;
        else                 t = 4'd0;
        return {t, 4'(v - 8'(t) * 8'd10)};
    endfunction

    always_comb begin
        {min_tens, min_ones} = to_bcd(min_left);
        {sec_tens, sec_ones} = to_bcd(sec_left);
    end

endmodule
